// File: rtl/multi_port_fifo_if.sv
// rtl/multi_port_fifo_if.sv - push/pop bundle for the multi-port circular FIFO
interface multi_port_fifo_if #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int IN_PORTS  = 3,
    parameter int OUT_PORTS = 3
);
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int NW = $clog2(IN_PORTS) + 1;
    localparam int OW = $clog2(OUT_PORTS) + 1;

    logic [IN_PORTS-1:0][WIDTH-1:0]  data_in;
    logic [NW-1:0]                   push_num;
    logic                            push_accept;
    logic [OUT_PORTS-1:0][WIDTH-1:0] data_out;
    logic [OUT_PORTS-1:0]            data_out_valid;
    logic [OW-1:0]                   pop_num;
    logic [PW-1:0]                   count;
    logic [PW-1:0]                   free_space;

    modport master (
        output data_in, push_num, pop_num,
        input  push_accept, data_out, data_out_valid, count, free_space
    );

    modport slave (
        input  data_in, push_num, pop_num,
        output push_accept, data_out, data_out_valid, count, free_space
    );
endinterface

// File: rtl/multi_port_fifo.sv
// rtl/multi_port_fifo.sv - circular buffer with IN_PORTS write ports and OUT_PORTS read ports
module multi_port_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int IN_PORTS  = 3,
    parameter int OUT_PORTS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    multi_port_fifo_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int NW = $clog2(IN_PORTS) + 1;
    localparam int OW = $clog2(OUT_PORTS) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    occupancy;
    logic [PW-1:0]    room;
    logic [PW-1:0]    push_len;
    logic [PW-1:0]    pop_req;
    logic [PW-1:0]    pop_len;
    logic             accept;
    logic             do_push;

    // Acceptance uses pre-pop room so same-cycle push and pop never alias a slot.
    always_comb begin
        occupancy = wr_ptr - rd_ptr;
        room      = PW'(DEPTH) - occupancy;
        push_len  = (bus.push_num > NW'(IN_PORTS)) ? PW'(IN_PORTS) : PW'(bus.push_num);
        pop_req   = (bus.pop_num > OW'(OUT_PORTS)) ? PW'(OUT_PORTS) : PW'(bus.pop_num);
        pop_len   = (pop_req > occupancy) ? occupancy : pop_req;
        accept    = (push_len <= room);
        do_push   = accept && (push_len != '0) && !flush && !rst;
    end

    assign bus.push_accept = accept;
    assign bus.count       = occupancy;
    assign bus.free_space  = room;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + push_len;
            end
            rd_ptr <= rd_ptr + pop_len;
        end
    end

    // Payload storage carries no reset; validity comes only from the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            for (int i = 0; i < IN_PORTS; i++) begin
                if (PW'(i) < push_len) begin
                    mem[wr_ptr[AW-1:0] + AW'(i)] <= bus.data_in[i];
                end
            end
        end
    end

    always_comb begin
        bus.data_out       = '0;
        bus.data_out_valid = '0;
        for (int i = 0; i < OUT_PORTS; i++) begin
            bus.data_out[i]       = mem[rd_ptr[AW-1:0] + AW'(i)];
            bus.data_out_valid[i] = (occupancy > PW'(i));
        end
    end
endmodule

// File: tb/tb_multi_port_fifo.sv
// tb/tb_multi_port_fifo.sv - randomized and directed bench for multi_port_fifo against a queue model
module tb_multi_port_fifo;
    localparam int WIDTH     = 32;
    localparam int DEPTH     = 16;
    localparam int IN_PORTS  = 3;
    localparam int OUT_PORTS = 3;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    multi_port_fifo_if #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .IN_PORTS(IN_PORTS), .OUT_PORTS(OUT_PORTS)
    ) bus ();

    multi_port_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .IN_PORTS(IN_PORTS), .OUT_PORTS(OUT_PORTS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [IN_PORTS-1:0][WIDTH-1:0] d;
    logic [WIDTH-1:0] model [$];
    logic [WIDTH-1:0] popped [$];
    bit capture = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_d(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c);
        d[0] = a;
        d[1] = b;
        d[2] = c;
    endtask

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One clock: drive at negedge, compare against the model, update the model at the edge.
    task automatic step(input int pn, input int pp, input bit fl, input bit rs);
        int  sz;
        int  pc;
        int  pe;
        bit  acc;
        bus.push_num = 3'(pn);
        bus.pop_num  = 3'(pp);
        bus.data_in  = d;
        flush        = fl;
        rst          = rs;
        #1;
        sz  = model.size();
        pc  = min_int(pn, IN_PORTS);
        pe  = min_int(min_int(pp, OUT_PORTS), sz);
        acc = (pc <= DEPTH - sz);
        check("accept", 64'(bus.push_accept), 64'(acc));
        check("count", 64'(bus.count), 64'(sz));
        check("free", 64'(bus.free_space), 64'(DEPTH - sz));
        check("valid", 64'(bus.data_out_valid), 64'((1 << min_int(sz, OUT_PORTS)) - 1));
        check("inv_sum", 64'(bus.count) + 64'(bus.free_space), 64'(DEPTH));
        for (int i = 0; i < OUT_PORTS; i++) begin
            if (i < sz) check($sformatf("dout%0d", i), 64'(bus.data_out[i]), 64'(model[i]));
        end
        if (capture && !rs && !fl) begin
            for (int i = 0; i < pe; i++) popped.push_back(bus.data_out[i]);
        end
        @(posedge clk);
        if (rs || fl) begin
            model.delete();
        end else begin
            repeat (pe) void'(model.pop_front());
            if (acc) begin
                for (int i = 0; i < pc; i++) model.push_back(d[i]);
            end
        end
        @(negedge clk);
        bus.push_num = '0;
        bus.pop_num  = '0;
        flush        = 1'b0;
        rst          = 1'b0;
    endtask

    initial begin
        int next_val;
        int pn;
        bit acc;
        rst          = 1'b1;
        flush        = 1'b0;
        bus.push_num = '0;
        bus.pop_num  = '0;
        bus.data_in  = '0;
        d            = '0;
        @(negedge clk);

        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("t1_count", 64'(bus.count), 64'd0);
        check("t1_free", 64'(bus.free_space), 64'd16);
        check("t1_valid", 64'(bus.data_out_valid), 64'd0);
        bus.push_num = 3'd3;
        #1;
        check("t1_accept", 64'(bus.push_accept), 64'd1);
        bus.push_num = '0;

        set_d(32'h11, 32'h22, 32'h33);
        step(3, 0, 0, 0);
        check("t2_count", 64'(bus.count), 64'd3);
        check("t2_valid", 64'(bus.data_out_valid), 64'b111);
        check("t2_d0", 64'(bus.data_out[0]), 64'h11);
        check("t2_d1", 64'(bus.data_out[1]), 64'h22);
        check("t2_d2", 64'(bus.data_out[2]), 64'h33);
        step(0, 2, 0, 0);
        check("t2_pop_count", 64'(bus.count), 64'd1);
        check("t2_pop_d0", 64'(bus.data_out[0]), 64'h33);
        check("t2_pop_valid", 64'(bus.data_out_valid), 64'b001);

        step(0, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            set_d(32'h100 + 32'(3 * k), 32'h101 + 32'(3 * k), 32'h102 + 32'(3 * k));
            step(3, 0, 0, 0);
        end
        check("t3_count15", 64'(bus.count), 64'd15);
        set_d(32'hdead0, 32'hdead1, 32'hdead2);
        bus.push_num = 3'd2;
        #1;
        check("t3_reject", 64'(bus.push_accept), 64'd0);
        step(2, 0, 0, 0);
        check("t3_hold15", 64'(bus.count), 64'd15);
        set_d(32'h10f, 32'h0, 32'h0);
        step(1, 0, 0, 0);
        check("t3_count16", 64'(bus.count), 64'd16);
        check("t3_free0", 64'(bus.free_space), 64'd0);

        set_d(32'hbad0, 32'hbad1, 32'hbad2);
        step(3, 3, 0, 0);
        check("t4_count13", 64'(bus.count), 64'd13);
        check("t4_head", 64'(bus.data_out[0]), 64'h103);
        set_d(32'h200, 32'h201, 32'h202);
        step(3, 1, 0, 0);
        check("t4_count15", 64'(bus.count), 64'd15);

        step(0, 0, 1, 0);
        capture  = 1'b1;
        next_val = 1;
        for (int it = 0; it < 200 && popped.size() < 40; it++) begin
            pn = (next_val <= 40) ? min_int(3, 41 - next_val) : 0;
            set_d(32'(next_val), 32'(next_val + 1), 32'(next_val + 2));
            acc = (pn <= DEPTH - model.size());
            step(pn, 2, 0, 0);
            if (acc) next_val += pn;
        end
        capture = 1'b0;
        check("t5_len", 64'(popped.size()), 64'd40);
        for (int i = 0; i < 40; i++) begin
            if (i < popped.size()) check($sformatf("t5_seq%0d", i), 64'(popped[i]), 64'(i + 1));
        end

        step(0, 0, 1, 0);
        set_d(32'h77, 32'h0, 32'h0);
        step(1, 0, 0, 0);
        check("t6_count1", 64'(bus.count), 64'd1);
        step(0, 3, 0, 0);
        check("t6_overpop", 64'(bus.count), 64'd0);
        check("t6_valid", 64'(bus.data_out_valid), 64'd0);
        set_d(32'ha1, 32'ha2, 32'ha3);
        step(3, 0, 0, 0);
        step(3, 0, 0, 0);
        check("t6_count6", 64'(bus.count), 64'd6);
        step(3, 0, 1, 0);
        check("t6_flush", 64'(bus.count), 64'd0);
        for (int k = 0; k < 3; k++) step(3, 0, 0, 0);
        check("t6_count9", 64'(bus.count), 64'd9);
        step(3, 1, 0, 1);
        check("t6_reset", 64'(bus.count), 64'd0);

        for (int it = 0; it < 400; it++) begin
            set_d($urandom, $urandom, $urandom);
            step($urandom_range(0, 7), $urandom_range(0, 7),
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
